serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial WIDTH-bit adder controller. Two half_adder instances form one
//   full-adder cell. This block uses that cell once per clock, LSB first, to add
//   two WIDTH-bit operands plus a carry-in.
//   A start/busy/done handshake sequences the operation. The result is
//   registered and holds until the next operation completes.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//   clk     in   1       rising-edge clock; the only clock in the block
//   rst_n   in   1       reset, synchronous, active-low
//   start   in   1       request an add; sampled only in IDLE
//   a       in   WIDTH   operand A; captured on the accepted start cycle
//   b       in   WIDTH   operand B; captured on the accepted start cycle
//   cin     in   1       carry-in; captured on the accepted start cycle
//   busy    out  1       high in RUN and DONE
//   done    out  1       1-cycle pulse; sum and cout are valid from this cycle on
//   sum     out  WIDTH   registered result (a+b+cin) mod 2^WIDTH
//   cout    out  1       registered carry-out of the MSB
// BEHAVIOUR
//   Reset:
//     - rst_n=0 at a rising edge forces state=IDLE.
//     - Clears all internal regs: shift regs, carry, bit counter.
//     - Outputs: busy=0, done=0, sum=0, cout=0.
//     - Reset mid-operation aborts the add; no done is produced.
//   Datapath: a_sh, b_sh are right-shift regs, carry is a 1-bit reg, cnt is
//   a $clog2(WIDTH)-bit counter, s_sh is the result shift reg. Each cell eval:
//     - ha0 = half_adder(a_sh[0], b_sh[0])
//     - ha1 = half_adder(ha0.s, carry)
//     - bit = ha1.s
//     - nc  = ha0.c | ha1.c
//   FSM states:
//     IDLE -> RUN when start=1:
//       - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0
//       - sum and cout keep their old values
//     RUN, every cycle:
//       - s_sh <= {bit, s_sh[WIDTH-1:1]}
//       - a_sh, b_sh shift right 1 (zero fill)
//       - carry <= nc, cnt <= cnt+1
//     RUN -> DONE on the cycle cnt==WIDTH-1, which processes the MSB.
//       On that edge:
//       - sum  <= {bit, s_sh[WIDTH-1:1]}
//       - cout <= nc
//       - done <= 1
//     DONE -> IDLE unconditionally after one cycle; done returns to 0.
//   Timing:
//     - Latency: start accepted at edge T -> done=1 in the cycle after edge
//       T+WIDTH.
//     - Next start can be accepted at edge T+WIDTH+2, so throughput is one add
//       per WIDTH+2 cycles.
//   start rules:
//     - start while busy=1 (RUN or DONE) is ignored and not queued.
//     - Operand and cin changes after capture do not affect the result in
//       progress.
//   Result hold: sum and cout change only on the RUN->DONE edge or on reset.
//     They stay stable through IDLE and through the next RUN.
//   Overflow: the result wraps mod 2^WIDTH; the carry out of the MSB is cout.
//   No combinational path from any input to any output.
// TESTING (WIDTH=8 unless stated; T = edge where start is accepted)
//   1. Reset, then 0x00+0x00, cin=0:
//      -> sum=0x00, cout=0; done pulses exactly once, after edge T+8;
//         busy high 9 cycles.
//   2. 0xFF+0x01, cin=0:
//      -> sum=0x00, cout=1 (full carry ripple).
//   3. 0xA5+0x5A, cin=1:
//      -> sum=0x00, cout=1.
//   4. 0x3C+0x42, cin=0, with start held high and a/b changed every cycle
//      during RUN:
//      -> sum=0x7E, cout=0.
//      -> Only one done pulse; the next add begins at edge T+10.
//   5. Assert rst_n=0 for 1 cycle at cnt==4 of an add:
//      -> busy=0, sum=0, cout=0 next cycle; no done.
//      -> A following 0x01+0x01 gives sum=0x02.
//   6. WIDTH=4, exhaustive over all 512 combinations of (a, b, cin):
//      -> {cout,sum} == a+b+cin for every case; done latency 5 cycles each.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half adders) is reused
// once per clock, LSB first, under a start/busy/done handshake.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, sum_q, s_nxt;
  logic [WIDTH-2:0] s_sh;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q;
  logic             ha0_s, ha0_c, ha1_s, ha1_c, nc, last;

  half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(ha1_s), .c(ha1_c));

  assign nc    = ha0_c | ha1_c;
  assign s_nxt = {ha1_s, s_sh};
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // s_sh holds only the WIDTH-1 bits already produced; the MSB joins on the last edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sh  <= bus.a;
          b_sh  <= bus.b;
          carry <= bus.cin;
          cnt   <= '0;
        end
        RUN: begin
          s_sh  <= s_nxt[WIDTH-1:1];
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= nc;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum_q  <= s_nxt;
            cout_q <= nc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
